// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end for one shared, fixed-latency pipelined
// multiplier. The winning requester's operands go to the multiplier in the
// cycle they are granted. A tag pipeline follows each product through the
// multiplier. Finished products are queued in a result FIFO and returned on
// one tagged response channel. Issue is credit-limited, so the FIFO always
// has a free slot when a product reaches it.
module mul_arbiter #(
   parameter int WIDTH = 64,
   parameter int NREQ  = 4,
   parameter int LAT   = 3,
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   output logic [WIDTH-1:0]        mul_a,
   output logic [WIDTH-1:0]        mul_b,
   input  logic [2*WIDTH-1:0]      mul_y,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [2*WIDTH-1:0]      rsp_y,
   output logic                    busy
);

   localparam int ID_W  = $clog2(NREQ);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [ID_W:0]    NREQ_C   = (ID_W + 1)'(NREQ);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NREQ - 1);
   localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   // Arbitration state and signals
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W:0]      cand;
   logic [ID_W-1:0]    winner;
   logic               found;
   logic               issue_ok;
   logic               issue;
   logic               issue_out;

   // Tag pipeline that runs alongside the multiplier stages
   logic [LAT-1:0]     vld_q, vld_d;
   logic [ID_W-1:0]    id_q [LAT];
   logic [ID_W-1:0]    id_d [LAT];
   logic [CNT_W-1:0]   inflight;
   logic [CNT_W:0]     occupancy;

   // Result FIFO
   logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [2*WIDTH-1:0] mem_y_q  [DEPTH];
   logic [ID_W-1:0]    mem_id_q [DEPTH];
   logic               push;
   logic               pop;

   // Round-robin scan starting at rr_ptr. The loop runs from the farthest
   // candidate down to the nearest, so the nearest requester that is valid
   // is assigned last and wins.
   // NOTE: combinational blocks use blocking '=' and give every output a
   // default first, so no latch is inferred and later statements see the
   // values just computed.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
         if (cand >= NREQ_C) cand = cand - NREQ_C;
         if (req_valid[cand[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[ID_W-1:0];
         end
      end
   end

   // Credit check: count products in flight plus products queued, using
   // only registered state.
   always_comb begin
      inflight = '0;
      for (int k = 0; k < LAT; k++) inflight = inflight + CNT_W'(vld_q[k]);
      occupancy = {1'b0, fifo_count_q} + {1'b0, inflight};
      issue_ok  = (occupancy < DEPTH_C);
   end

   // issue drives the internal state. Only the outputs are gated with the
   // reset, so req_ready and the operands read as zero while reset is held.
   assign issue     = found & issue_ok;
   assign issue_out = issue & rst_n;

   // The grant and the operand steering to the multiplier
   always_comb begin
      req_ready = '0;
      if (issue_out) req_ready[winner] = 1'b1;
   end

   assign mul_a = issue_out ? req_a[int'(winner)*WIDTH +: WIDTH] : '0;
   assign mul_b = issue_out ? req_b[int'(winner)*WIDTH +: WIDTH] : '0;

   // Next state for the pointer, the tag pipe and the FIFO bookkeeping
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (issue) rr_ptr_d = (winner == ID_LAST) ? '0 : winner + 1'b1;

      vld_d[0] = issue;
      id_d[0]  = winner;
      for (int k = 1; k < LAT; k++) begin
         vld_d[k] = vld_q[k-1];
         id_d[k]  = id_q[k-1];
      end

      wr_ptr_d = wr_ptr_q;
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      rd_ptr_d = rd_ptr_q;
      if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;

      fifo_count_d = fifo_count_q;
      case ({push, pop})
         2'b10:   fifo_count_d = fifo_count_q + 1'b1;
         2'b01:   fifo_count_d = fifo_count_q - 1'b1;
         default: fifo_count_d = fifo_count_q;
      endcase
   end

   // Control registers. A reset discards anything still in the multiplier
   // by clearing its tags.
   // NOTE: sequential blocks use non-blocking '<=' so that every flop
   // samples the values from before the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q     <= '0;
         vld_q        <= '0;
         for (int k = 0; k < LAT; k++) id_q[k] <= '0;
         fifo_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         vld_q        <= vld_d;
         id_q         <= id_d;
         fifo_count_q <= fifo_count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   assign push = vld_q[LAT-1];
   assign pop  = rsp_valid & rsp_ready;

   // FIFO storage, written when a tagged product leaves the multiplier.
   // NOTE: the storage array has no reset. The count and the pointers
   // decide which entries are valid, and the head is masked when the FIFO
   // is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_y_q[wr_ptr_q]  <= mul_y;
         mem_id_q[wr_ptr_q] <= id_q[LAT-1];
      end
   end

   assign rsp_valid = (fifo_count_q != '0);
   assign rsp_y     = rsp_valid ? mem_y_q[rd_ptr_q]  : '0;
   assign rsp_id    = rsp_valid ? mem_id_q[rd_ptr_q] : '0;
   assign busy      = (inflight != '0) || (fifo_count_q != '0);

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: randomized, scoreboarded bench for mul_arbiter. It
// contains a behavioural 3-stage multiplier. The reference model tracks
// four things: the round-robin pointer, the credit as products issued minus
// products popped, a queue of expected responses, and the cycle in which
// each response first becomes visible.
module tb_mul_arbiter;

   localparam int WIDTH = 64;
   localparam int NREQ  = 4;
   localparam int LAT   = 3;
   localparam int DEPTH = 8;
   localparam int ID_W  = $clog2(NREQ);

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [WIDTH-1:0]      mul_a;
   logic [WIDTH-1:0]      mul_b;
   logic [2*WIDTH-1:0]    mul_y;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [2*WIDTH-1:0]    rsp_y;
   logic                  busy;

   always #5 clk = ~clk;

   mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_y     (mul_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .busy      (busy)
   );

   // External multiplier with no reset: an input register, a product
   // register and an output register.
   logic [WIDTH-1:0]   ma_r, mb_r;
   logic [2*WIDTH-1:0] mp_r, my_r;
   always @(posedge clk) begin
      ma_r <= mul_a;
      mb_r <= mul_b;
      mp_r <= {{WIDTH{1'b0}}, ma_r} * {{WIDTH{1'b0}}, mb_r};
      my_r <= mp_r;
   end
   assign mul_y = my_r;

   typedef struct {
      int                 id;
      logic [2*WIDTH-1:0] y;
      int                 due;
   } exp_t;

   exp_t             sb[$];
   int               n_checks    = 0;
   int               n_pass      = 0;
   int               cyc         = 0;
   int               issued      = 0;
   int               popped      = 0;
   int               rr          = 0;
   int               dut_accepts = 0;
   int               acc_mark;
   logic             mon_exp_v;
   logic [WIDTH-1:0] a_op [NREQ];
   logic [WIDTH-1:0] b_op [NREQ];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [2*WIDTH-1:0] act,
                        input logic [2*WIDTH-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [WIDTH-1:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   // Drive one cycle, then check the grant, the operands and busy against
   // the model. Any issue the model predicts goes into the scoreboard.
   task automatic drive(input logic [NREQ-1:0] vld, input logic rdy);
      int                 outstanding;
      int                 win;
      logic               found;
      logic [NREQ-1:0]    exp_ready;
      logic [2*WIDTH-1:0] prod;
      exp_t               e;
      @(negedge clk);
      req_valid = vld;
      rsp_ready = rdy;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*WIDTH +: WIDTH] = a_op[i];
         req_b[i*WIDTH +: WIDTH] = b_op[i];
      end
      #1;
      if ((req_valid & req_ready) != '0) dut_accepts++;
      outstanding = issued - popped;
      check("busy", busy, outstanding != 0);
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && vld[(rr + k) % NREQ]) begin
            found = 1'b1;
            win   = (rr + k) % NREQ;
         end
      end
      exp_ready = '0;
      if (found && outstanding < DEPTH) exp_ready[win] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      if (exp_ready != '0) begin
         check("mul_a", mul_a, a_op[win]);
         check("mul_b", mul_b, b_op[win]);
         prod  = {{WIDTH{1'b0}}, a_op[win]} * {{WIDTH{1'b0}}, b_op[win]};
         e.id  = win;
         e.y   = prod;
         e.due = cyc + LAT + 1;
         sb.push_back(e);
         issued++;
         rr = (win + 1) % NREQ;
      end else begin
         check("mul_idle", {mul_a, mul_b}, '0);
      end
   endtask

   // Hold reset low for one cycle while every requester is valid. All
   // outputs must go idle at once.
   task automatic pulse_reset();
      @(negedge clk);
      req_valid = '1;
      rsp_ready = 1'b1;
      rst_n     = 1'b0;
      sb.delete();
      issued = 0;
      popped = 0;
      rr     = 0;
      #1;
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_req_ready", req_ready, '0);
      check("rst_rsp_y", rsp_y, '0);
      check("rst_rsp_id", rsp_id, '0);
      check("rst_mul", {mul_a, mul_b}, '0);
      @(negedge clk);
      req_valid = '0;
      rst_n     = 1'b1;
   endtask

   // Monitor: compares rsp_valid in every cycle and checks each response
   // against the head of the scoreboard.
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         mon_exp_v = (sb.size() != 0) && (sb[0].due <= cyc);
         check("rsp_valid", rsp_valid, mon_exp_v);
         if (mon_exp_v) begin
            check("rsp_id", rsp_id, sb[0].id);
            check("rsp_y", rsp_y, sb[0].y);
            if (rsp_ready) begin
               void'(sb.pop_front());
               popped++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b0;
      req_a     = '1;
      req_b     = '1;
      for (int i = 0; i < NREQ; i++) begin
         a_op[i] = '0;
         b_op[i] = '0;
      end
      #3;
      check("init_req_ready", req_ready, '0);
      check("init_rsp_valid", rsp_valid, 1'b0);
      check("init_busy", busy, 1'b0);
      check("init_rsp_y", rsp_y, '0);
      check("init_mul", {mul_a, mul_b}, '0);
      @(negedge clk);
      @(negedge clk);
      req_valid = '0;
      rst_n     = 1'b1;

      // Single request from requester 2
      a_op[2] = 64'd3;
      b_op[2] = 64'd5;
      drive(4'b0100, 1'b1);
      repeat (8) drive(4'b0000, 1'b1);

      // Contention starting from reset: expected grants are 0,1,2,3,0,...
      pulse_reset();
      for (int i = 0; i < NREQ; i++) begin
         a_op[i] = WIDTH'(i + 1);
         b_op[i] = 64'd10;
      end
      repeat (8) drive(4'b1111, 1'b1);
      repeat (8) drive(4'b0000, 1'b1);

      // Back-pressure: with rsp_ready low, exactly DEPTH accepts, then drain
      acc_mark = dut_accepts;
      repeat (14) begin
         a_op[0] = rand64();
         b_op[0] = rand64();
         drive(4'b0001, 1'b0);
      end
      check("bp_accepts", dut_accepts - acc_mark, DEPTH);
      repeat (16) begin
         a_op[0] = rand64();
         b_op[0] = rand64();
         drive(4'b0001, 1'b1);
      end
      repeat (10) drive(4'b0000, 1'b1);

      // Extreme operands
      a_op[1] = '1;
      b_op[1] = '1;
      a_op[3] = '0;
      b_op[3] = '1;
      drive(4'b0010, 1'b1);
      drive(4'b1000, 1'b1);
      repeat (6) drive(4'b0000, 1'b1);

      // Reset mid-operation: reset arrives with 3 products in flight and 2
      // queued. The next grant must go to requester 0.
      for (int i = 0; i < NREQ; i++) begin
         a_op[i] = rand64();
         b_op[i] = rand64();
      end
      repeat (5) drive(4'b1111, 1'b0);
      pulse_reset();
      repeat (4) drive(4'b1111, 1'b1);
      repeat (8) drive(4'b0000, 1'b1);

      // Fairness between requesters 1 and 3
      repeat (12) begin
         a_op[1] = rand64();
         a_op[3] = rand64();
         drive(4'b1010, 1'($urandom_range(0, 1)));
      end
      repeat (12) drive(4'b0000, 1'b1);

      // Random traffic
      repeat (300) begin
         for (int i = 0; i < NREQ; i++) begin
            a_op[i] = rand64();
            b_op[i] = rand64();
         end
         drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      end
      repeat (20) drive(4'b0000, 1'b1);
      #5;
      check("sb_drained", sb.size(), 0);
      check("idle_busy", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter and sequencer that shares one fixed-latency pipelined array multiplier among NREQ requesters. It issues one operand pair per cycle into the multiplier and tracks each in-flight product with a tag pipeline. Finished products go into a result FIFO and return on a single tagged response channel. A credit check guarantees that no product is ever dropped under response back-pressure.

## Interface
- WIDTH, 64, operand width; the multiplier product is 2*WIDTH.
- NREQ, 4, number of requesters (≥2).
- LAT, 3, multiplier latency in clock edges from operands presented to y valid (input reg, mid-stage reg, output reg).
- DEPTH, 8, result FIFO entries; must be ≥ LAT+2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester operand-pair valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing as req_a.
- mul_a  out  WIDTH  operand A to the multiplier.
- mul_b  out  WIDTH  operand B to the multiplier.
- mul_y  in  2*WIDTH  product from the multiplier.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  clog2(NREQ)  index of the requester that owns rsp_y.
- rsp_y  out  2*WIDTH  product.
- busy  out  1  high when any product is in flight or the FIFO is non-empty.

## Operation
- Issue condition: issue_ok = (fifo_count + inflight) < DEPTH, where inflight = number of set bits in the valid pipe. Both values are registered state from the current cycle. A FIFO pop in the same cycle does not free a slot for that cycle's issue.
- Arbitration is combinational within the cycle:
  - Scan req_valid starting at rr_ptr, wrapping modulo NREQ; the first set bit wins.
  - req_ready[winner] = issue_ok; all other req_ready bits are 0.
  - An issue occurs when req_valid[i] & req_ready[i].
- On issue: mul_a/mul_b = the winner's req_a/req_b slice in the same cycle. With no issue, mul_a = mul_b = 0.
- rr_ptr update: on issue, rr_ptr <= (winner+1) mod NREQ. Otherwise rr_ptr holds.
- Tag pipeline, LAT stages of {valid, id}:
  - Stage 0 loads {issue, winner} at the edge.
  - Stage k loads stage k-1 at each edge; the pipeline never stalls.
- Capture: when stage LAT-1 is valid, mul_y and its id are written into the FIFO at the next edge. The credit rule guarantees the FIFO is never full at a write.
- FIFO: depth DEPTH, first-in first-out.
  - rsp_valid = fifo non-empty; rsp_y/rsp_id come from the head entry.
  - Pop on rsp_valid & rsp_ready.
  - A simultaneous push and pop leaves the count unchanged. Pushes to an empty FIFO are not bypassed.
- Response order equals issue order.
- busy = inflight != 0 || fifo_count != 0.
- Reset (asynchronous, any time):
  - Clears the valid pipe, fifo_count, and the FIFO pointers; rr_ptr = 0.
  - Products already in the multiplier are discarded. The multiplier has no reset; its contents are ignored because the valid bits are cleared.

## Timing
- Reset values: req_ready = 0 while rst_n is low; rsp_valid = 0, rsp_id = 0, rsp_y = 0 (head read masked when empty); mul_a = mul_b = 0; busy = 0.
- Request handshake in cycle t gives rsp_valid high in cycle t+LAT+1 (4 cycles at the default LAT) when the FIFO is empty.
- Throughput: one issue per cycle while rsp_ready stays high, given DEPTH ≥ LAT+2.
- Back-pressure with rsp_ready low: at most DEPTH-LAT further issues after the FIFO starts filling. req_ready is 0 whenever fifo_count + inflight = DEPTH.
- req_ready may depend combinationally on req_valid. rsp_valid, rsp_y and rsp_id are registered (FIFO head).

## Test plan
- Single request: requester 2 sends a=3, b=5 in cycle 0. Expect rsp_valid in cycle 4 with rsp_y=15, rsp_id=2; busy low from cycle 5 when rsp_ready=1.
- Contention: all 4 requesters hold req_valid from reset, each with distinct operands (a=i+1, b=10). Expect grants 0,1,2,3,0,… on consecutive cycles, and responses 10,20,30,40 in that order, one per cycle, from cycle 4.
- Back-pressure: rsp_ready=0 with requester 0 continuously valid. Expect exactly 8 accepts; then req_ready=0, fifo_count=8, no lost or duplicated products. Raise rsp_ready: 8 in-order responses drain, and issue resumes one cycle after the first pop.
- Extremes: a = b = 2^64-1. Expect rsp_y = 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. a=0, b=max gives rsp_y=0.
- Reset mid-operation: assert rst_n low for one cycle while 3 products are in flight and 2 are queued. Expect rsp_valid=0 and busy=0 immediately, no stale responses afterwards, and the next grant going to requester 0.
- Fairness: requesters 1 and 3 always valid, 0 and 2 idle. Expect strict alternation 1,3,1,3 with no starvation.
